i_ref_sweep_ctrl: RTL and testbench

- Upstream stage of the max-stable-current sampler; produces the `i_ref`, `ready` and `went_unstable` it consumes.
- Ramps the reference-current DAC code from `START_CODE` in `STEP` increments. After each step it waits a settle time, then counts comparator toggles over an observation window.
- Each code is declared stable (`ready` pulse) or unstable (`went_unstable` pulse). The sweep ends at the first unstable code or when the code range is exhausted.

---
 rtl/i_ref_sweep_ctrl_pkg.sv | 25 ++
 rtl/i_ref_sweep_ctrl_edge_window_counter.sv | 73 +++++++
 rtl/i_ref_sweep_ctrl.sv | 179 +++++++++++++++++
 tb/tb_i_ref_sweep_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_ref_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// i_ref_pkg
// Shared definitions for the reference-current sweep controller and the
// downstream max-stable-current sampler.
//   I_REF_BUS_WIDTH : default DAC code width.
//   sweep_state_t   : sweep controller state encoding.
//   cnt_width()     : width needed for a counter holding 0..n-1 (minimum 1).
// -----------------------------------------------------------------------------
package i_ref_pkg;

    localparam int unsigned I_REF_BUS_WIDTH = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        WINDOW = 3'd2,
        EVAL   = 3'd3,
        DONE   = 3'd4
    } sweep_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i_ref_sweep_ctrl_edge_window_counter.sv
// -----------------------------------------------------------------------------
// edge_window_counter
// Samples the comparator, detects rising edges and counts them (saturating
// at EDGE_THRESH) while count_en is high.
// Build option: define I_REF_SWEEP_CMP_SYNC_EN to sample cmp_in through a
// 2-flop synchronizer; otherwise a single sampling flop is used.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cmp_in       : comparator input (asynchronous when the synchronizer is on)
//   clear        : zero the edge count
//   count_en     : count rising edges this cycle
//   thresh_hit   : edge count has reached EDGE_THRESH
// -----------------------------------------------------------------------------
module edge_window_counter
    import i_ref_pkg::*;
#(
    parameter int unsigned EDGE_THRESH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cmp_in,
    input  logic clear,
    input  logic count_en,
    output logic thresh_hit
);

    localparam int unsigned CW = cnt_width(EDGE_THRESH + 1);

    logic          cmp_s;
    logic          cmp_prev;
    logic          rise;
    logic [CW-1:0] edge_cnt;

`ifdef I_REF_SWEEP_CMP_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], cmp_in};
    end

    assign cmp_s = sync_q[1];
`else
    logic samp_q;

    always_ff @(posedge clk) begin
        if (rst) samp_q <= 1'b0;
        else     samp_q <= cmp_in;
    end

    assign cmp_s = samp_q;
`endif

    // The previous sample tracks every cycle, so on window entry it already
    // holds the last pre-window level: a level high at window start is not
    // an edge.
    always_ff @(posedge clk) begin
        if (rst) cmp_prev <= 1'b0;
        else     cmp_prev <= cmp_s;
    end

    assign rise = cmp_s & ~cmp_prev;

    always_ff @(posedge clk) begin
        if (rst || clear)
            edge_cnt <= '0;
        else if (count_en && rise && (edge_cnt < CW'(EDGE_THRESH)))
            edge_cnt <= edge_cnt + CW'(1);
    end

    assign thresh_hit = (edge_cnt >= CW'(EDGE_THRESH));

endmodule

// File: rtl/i_ref_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// i_ref_sweep_ctrl
// Ramps the reference-current DAC code from START_CODE in STEP increments.
// Each code settles for SETTLE_CYCLES, then comparator rising edges are
// counted for WINDOW_CYCLES; one EVAL cycle then pulses ready (stable) or
// went_unstable. The sweep stops at the first unstable code or when the next
// code would exceed the code range.
// Build option: I_REF_SWEEP_CMP_SYNC_EN (see edge_window_counter).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   enable         : level; high starts and holds the sweep
//   cmp_in         : oscillation comparator
//   i_ref          : current DAC code
//   ready          : 1-cycle pulse, current code stable
//   went_unstable  : 1-cycle pulse, current code unstable
//   busy           : sweep in progress
//   done           : sweep finished, held until enable falls
//   exhausted      : with done, range ended without instability
// -----------------------------------------------------------------------------
module i_ref_sweep_ctrl
    import i_ref_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = I_REF_BUS_WIDTH,
    parameter int unsigned START_CODE    = 0,
    parameter int unsigned STEP          = 1,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES = 64,
    parameter int unsigned EDGE_THRESH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 cmp_in,
    output logic [BUS_WIDTH-1:0] i_ref,
    output logic                 ready,
    output logic                 went_unstable,
    output logic                 busy,
    output logic                 done,
    output logic                 exhausted
);

    localparam int unsigned CYC_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ?
                                      SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int unsigned CCW     = cnt_width(CYC_MAX);

    localparam logic [BUS_WIDTH-1:0] START_VAL = BUS_WIDTH'(START_CODE);
    localparam logic [BUS_WIDTH:0]   STEP_EXT  = (BUS_WIDTH + 1)'(STEP);

    sweep_state_t         state_q, state_d;
    logic [CCW-1:0]       cyc_q, cyc_d;
    logic [BUS_WIDTH-1:0] i_ref_q, i_ref_d;
    logic                 exh_q, exh_d;

    logic                 thresh_hit;
    logic                 cnt_clear;
    logic                 cnt_en;
    logic [BUS_WIDTH:0]   next_code;
    logic                 code_ovf;
    logic                 settle_last;
    logic                 window_last;

    // One extra bit catches the step that would run past the top code.
    assign next_code   = {1'b0, i_ref_q} + STEP_EXT;
    assign code_ovf    = next_code[BUS_WIDTH];
    assign settle_last = (cyc_q == CCW'(SETTLE_CYCLES - 1));
    assign window_last = (cyc_q == CCW'(WINDOW_CYCLES - 1));

    edge_window_counter #(
        .EDGE_THRESH (EDGE_THRESH)
    ) u_edge_cnt (
        .clk        (clk),
        .rst        (rst),
        .cmp_in     (cmp_in),
        .clear      (cnt_clear),
        .count_en   (cnt_en),
        .thresh_hit (thresh_hit)
    );

    // State register and sweep datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            i_ref_q <= START_VAL;
            exh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            i_ref_q <= i_ref_d;
            exh_q   <= exh_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        i_ref_d = i_ref_q;
        exh_d   = exh_q;
        case (state_q)
            IDLE: begin
                cyc_d   = '0;
                i_ref_d = START_VAL;
                exh_d   = 1'b0;
                if (enable) state_d = SETTLE;
            end
            SETTLE: begin
                if (!enable) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    i_ref_d = START_VAL;
                end else if (settle_last) begin
                    state_d = WINDOW;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CCW'(1);
                end
            end
            WINDOW: begin
                if (!enable) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    i_ref_d = START_VAL;
                end else if (window_last) begin
                    state_d = EVAL;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CCW'(1);
                end
            end
            EVAL: begin
                cyc_d = '0;
                if (!enable) begin
                    state_d = IDLE;
                    i_ref_d = START_VAL;
                end else if (thresh_hit) begin
                    state_d = DONE;
                    exh_d   = 1'b0;
                end else if (code_ovf) begin
                    state_d = DONE;
                    exh_d   = 1'b1;
                end else begin
                    state_d = SETTLE;
                    i_ref_d = next_code[BUS_WIDTH-1:0];
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                    i_ref_d = START_VAL;
                    exh_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                i_ref_d = START_VAL;
                exh_d   = 1'b0;
            end
        endcase
    end

    // Output decode (Moore) and edge counter control
    always_comb begin
        i_ref         = i_ref_q;
        ready         = (state_q == EVAL) && !thresh_hit;
        went_unstable = (state_q == EVAL) &&  thresh_hit;
        busy          = (state_q == SETTLE) || (state_q == WINDOW) ||
                        (state_q == EVAL);
        done          = (state_q == DONE);
        exhausted     = exh_q;
        // Count held at zero outside the window/eval span so every window
        // starts from zero; an abort also clears it immediately.
        cnt_clear     = !enable || (state_q == IDLE) || (state_q == SETTLE) ||
                        (state_q == DONE);
        cnt_en        = (state_q == WINDOW);
    end

endmodule

// File: tb/tb_i_ref_sweep_ctrl.sv
module tb_i_ref_sweep_ctrl;

    localparam int S   = 16;
    localparam int W   = 64;
    localparam int T   = 4;
    localparam int PER = S + W + 1;

    logic       clk = 1'b0;
    logic       rst, enable, cmp_in;
    logic [9:0] i_ref;
    logic       ready, went_unstable, busy, done, exhausted;

    logic       enable_ex, cmp_ex;
    logic [3:0] i_ref_ex;
    logic       ready_ex, went_unstable_ex, busy_ex, done_ex, exhausted_ex;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    int unst_cnt = 0;
    int ready_ex_cnt = 0;

    int plan_we[64];
    int plan_se[64];
    int toggle_from;

    always #5 clk = ~clk;

    i_ref_sweep_ctrl #(
        .BUS_WIDTH(10), .START_CODE(0), .STEP(1),
        .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .EDGE_THRESH(T)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cmp_in(cmp_in),
        .i_ref(i_ref), .ready(ready), .went_unstable(went_unstable),
        .busy(busy), .done(done), .exhausted(exhausted)
    );

    i_ref_sweep_ctrl #(
        .BUS_WIDTH(4), .START_CODE(0), .STEP(3),
        .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .EDGE_THRESH(T)
    ) dut_ex (
        .clk(clk), .rst(rst), .enable(enable_ex), .cmp_in(cmp_ex),
        .i_ref(i_ref_ex), .ready(ready_ex), .went_unstable(went_unstable_ex),
        .busy(busy_ex), .done(done_ex), .exhausted(exhausted_ex)
    );

    always @(posedge clk) begin
        if (!rst) begin
            if (ready)         ready_cnt    <= ready_cnt + 1;
            if (went_unstable) unst_cnt     <= unst_cnt + 1;
            if (ready_ex)      ready_ex_cnt <= ready_ex_cnt + 1;
        end
    end

    // Comparator level for sweep cycle cyc (cycle 0 = first cycle at START_CODE).
    // Settle pulses sit early in the settle span, window pulses well inside
    // the window, so either sampling latency keeps them on their side.
    function automatic logic cmp_level(input int cyc);
        int k  = cyc / PER;
        int ph = cyc % PER;
        if (toggle_from >= 0 && k >= toggle_from) return ((cyc / 4) % 2) == 1;
        if (k >= 64) return 1'b0;
        if (ph >= 2 && ph < 2 + 4 * plan_se[k] && ((ph - 2) % 4) < 2) return 1'b1;
        if (ph >= 24 && ph < 24 + 4 * plan_we[k] && ((ph - 24) % 4) < 2) return 1'b1;
        return 1'b0;
    endfunction

    // First code whose window sees at least EDGE_THRESH rising edges.
    function automatic int first_unstable();
        for (int k = 0; k < 64; k++) begin
            if (toggle_from >= 0 && k >= toggle_from) return k;
            if (plan_we[k] >= T) return k;
        end
        return 63;
    endfunction

    task automatic clear_plan();
        for (int k = 0; k < 64; k++) begin
            plan_we[k] = 0;
            plan_se[k] = 0;
        end
        toggle_from = -1;
    endtask

    // Runs one sweep from IDLE following the current plan; ends back in IDLE.
    task automatic run_sweep(input string name);
        int u  = first_unstable();
        int r0 = ready_cnt;
        int u0 = unst_cnt;
        enable = 1'b1;
        cmp_in = 1'b0;
        for (int cyc = 0; cyc <= PER * u + PER; cyc++) begin
            int k  = cyc / PER;
            int ph = cyc % PER;
            @(negedge clk);
            if (k <= u) begin
                if (ph == 0) begin
                    checks++;
                    if ({busy, i_ref} !== {1'b1, 10'(k)}) begin
                        errors++;
                        $display("FAIL %s code_start k=%0d: busy=%b i_ref=%0d, want busy=1 i_ref=%0d",
                                 name, k, busy, i_ref, k);
                    end
                end
                if (ph == 40) begin
                    checks++;
                    if ({ready, went_unstable, busy} !== 3'b001) begin
                        errors++;
                        $display("FAIL %s mid_window k=%0d: ready=%b unst=%b busy=%b, want 0 0 1",
                                 name, k, ready, went_unstable, busy);
                    end
                end
                if (ph == PER - 1) begin
                    checks++;
                    if ({ready, went_unstable, i_ref} !== {(k < u), (k == u), 10'(k)}) begin
                        errors++;
                        $display("FAIL %s eval k=%0d: ready=%b unst=%b i_ref=%0d, want %b %b %0d",
                                 name, k, ready, went_unstable, i_ref, (k < u), (k == u), k);
                    end
                end
            end else begin
                checks++;
                if ({done, exhausted, busy, i_ref} !== {3'b100, 10'(u)}) begin
                    errors++;
                    $display("FAIL %s done_state: done=%b exh=%b busy=%b i_ref=%0d, want 1 0 0 %0d",
                             name, done, exhausted, busy, i_ref, u);
                end
                checks++;
                if ((ready_cnt - r0) !== u || (unst_cnt - u0) !== 1) begin
                    errors++;
                    $display("FAIL %s pulse_count: ready=%0d unst=%0d, want %0d 1",
                             name, ready_cnt - r0, unst_cnt - u0, u);
                end
            end
            cmp_in = cmp_level(cyc);
        end
        enable = 1'b0;
        cmp_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, exhausted, busy, i_ref} !== {3'b000, 10'd0}) begin
            errors++;
            $display("FAIL %s back_to_idle: done=%b exh=%b busy=%b i_ref=%0d, want 0 0 0 0",
                     name, done, exhausted, busy, i_ref);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; cmp_in = 1'b0;
        enable_ex = 1'b0; cmp_ex = 1'b0;
        clear_plan();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({i_ref, ready, went_unstable, busy, done, exhausted} !== 15'd0) begin
                errors++;
                $display("FAIL reset_state: i_ref=%0d r=%b u=%b b=%b d=%b e=%b, want all 0",
                         i_ref, ready, went_unstable, busy, done, exhausted);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, i_ref} !== {1'b1, 10'd0}) begin
            errors++;
            $display("FAIL reset_release_start: busy=%b i_ref=%0d, want 1 0", busy, i_ref);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_unstable_at_20();
        clear_plan();
        toggle_from = 20;
        run_sweep("unstable20");
    endtask

    task automatic test_threshold_boundary();
        clear_plan();
        plan_we[0] = T - 1;
        plan_se[1] = 2;
        plan_we[2] = T;
        run_sweep("threshold");
    endtask

    task automatic test_random_sweep(input int n);
        clear_plan();
        for (int k = 0; k < 8; k++) begin
            plan_we[k] = $urandom_range(T - 1, 0);
            plan_se[k] = $urandom_range(2, 0);
        end
        plan_we[$urandom_range(6, 1)] = $urandom_range(6, T);
        run_sweep($sformatf("random%0d", n));
    endtask

    task automatic test_abort();
        int r0;
        clear_plan();
        r0 = ready_cnt;
        enable = 1'b1;
        cmp_in = 1'b0;
        for (int cyc = 0; cyc <= PER * 7 + 40; cyc++) @(negedge clk);
        checks++;
        if ({busy, i_ref, 7'(ready_cnt - r0)} !== {1'b1, 10'd7, 7'd7}) begin
            errors++;
            $display("FAIL abort_pre: busy=%b i_ref=%0d readies=%0d, want 1 7 7",
                     busy, i_ref, ready_cnt - r0);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, ready, went_unstable, i_ref} !== 14'd0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b r=%b u=%b i_ref=%0d, want all 0",
                     busy, done, ready, went_unstable, i_ref);
        end
        repeat (100) @(negedge clk);
        checks++;
        if ((ready_cnt - r0) !== 7 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_pulse: readies=%0d busy=%b, want 7 0", ready_cnt - r0, busy);
        end
        plan_we[1] = 5;
        run_sweep("abort_restart");
    endtask

    task automatic test_timing();
        int n = 0;
        bit seen = 0;
        clear_plan();
        enable = 1'b1;
        cmp_in = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ready) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timing_first_ready: no ready within 200 cycles, want one");
        end
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (ready) seen = 1;
        end
        checks++;
        if (!seen || n !== PER) begin
            errors++;
            $display("FAIL timing_period: seen=%b cycles=%0d, want 1 %0d", seen, n, PER);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exhaustion();
        enable_ex = 1'b1;
        cmp_ex    = 1'b0;
        for (int cyc = 0; cyc <= PER * 6; cyc++) begin
            int k  = cyc / PER;
            int ph = cyc % PER;
            @(negedge clk);
            if (k < 6 && ph == PER - 1) begin
                checks++;
                if ({ready_ex, went_unstable_ex, i_ref_ex} !== {2'b10, 4'(3 * k)}) begin
                    errors++;
                    $display("FAIL exhaust_eval k=%0d: ready=%b unst=%b i_ref=%0d, want 1 0 %0d",
                             k, ready_ex, went_unstable_ex, i_ref_ex, 3 * k);
                end
            end
        end
        checks++;
        if ({done_ex, exhausted_ex, busy_ex, i_ref_ex} !== {3'b110, 4'd15} || ready_ex_cnt !== 6) begin
            errors++;
            $display("FAIL exhaust_done: done=%b exh=%b busy=%b i_ref=%0d readies=%0d, want 1 1 0 15 6",
                     done_ex, exhausted_ex, busy_ex, i_ref_ex, ready_ex_cnt);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({done_ex, exhausted_ex, i_ref_ex} !== {2'b11, 4'd15}) begin
            errors++;
            $display("FAIL exhaust_hold: done=%b exh=%b i_ref=%0d, want 1 1 15",
                     done_ex, exhausted_ex, i_ref_ex);
        end
        enable_ex = 1'b0;
        @(negedge clk);
        checks++;
        if ({done_ex, exhausted_ex, busy_ex, i_ref_ex} !== 7'd0) begin
            errors++;
            $display("FAIL exhaust_idle: done=%b exh=%b busy=%b i_ref=%0d, want 0 0 0 0",
                     done_ex, exhausted_ex, busy_ex, i_ref_ex);
        end
    endtask

    initial begin
        test_reset();
        test_unstable_at_20();
        test_threshold_boundary();
        test_random_sweep(0);
        test_random_sweep(1);
        test_abort();
        test_timing();
        test_exhaustion();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
